// File: rtl/apb_charlcd_responder.sv
// apb_charlcd_responder: HD44780-style character LCD responder with DDRAM, busy flag and a bench peek port
module apb_charlcd_responder #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1600
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic [7:0] LCD_DATA_I,
    output logic [7:0] LCD_DATA_O,
    output logic       LCD_DATA_OE,
    input  logic [6:0] mon_addr,
    output logic [7:0] mon_data,
    output logic [6:0] ac,
    output logic       busy,
    output logic       disp_on,
    output logic       cur_on,
    output logic       blink_on,
    output logic [5:0] shift_ofs,
    output logic       cmd_strobe,
    output logic       err_busy
);
    localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, FILL, BUSY} state_t;

    function automatic logic ddr_valid(input logic [6:0] a);
        return (a < 7'h28) || (a >= 7'h40 && a < 7'h68);
    endfunction

    // line 0 maps to entries 0..39, line 1 (0x40..0x67) to entries 40..79
    function automatic logic [6:0] ddr_idx(input logic [6:0] a);
        return a[6] ? 7'(a[5:0]) + 7'd40 : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc)
            return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    endfunction

    function automatic logic [5:0] ofs_step(input logic [5:0] o, input logic inc);
        if (inc)
            return (o == 6'd39) ? 6'd0 : o + 6'd1;
        return (o == 6'd0) ? 6'd39 : o - 6'd1;
    endfunction

    // bus vector layout: {EN, RS, RW, DATA[7:0]}
    logic [10:0]   s1_q, s2_q, last_q;
    state_t        state_q, state_d;
    logic [6:0]    fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    ac_q, ac_d;
    logic          id_q, id_d, s_q, s_d;
    logic [2:0]    dcb_q, dcb_d;
    logic [5:0]    ofs_q, ofs_d;
    logic          strobe_q, strobe_d, err_q, err_d;
    logic [7:0]    mem_q [0:79];
    logic          we;
    logic [6:0]    wa;
    logic [7:0]    wd;
    logic          fall, wr, rd, rs_l;
    logic [7:0]    dat_l, rd_byte;

    assign fall  = last_q[10] & ~s2_q[10];
    assign rs_l  = last_q[9];
    assign wr    = fall & ~last_q[8];
    assign rd    = fall & last_q[8];
    assign dat_l = last_q[7:0];

    assign busy        = state_q != IDLE;
    assign ac          = ac_q;
    assign {disp_on, cur_on, blink_on} = dcb_q;
    assign shift_ofs   = ofs_q;
    assign cmd_strobe  = strobe_q;
    assign err_busy    = err_q;

    assign rd_byte     = ddr_valid(ac_q) ? mem_q[ddr_idx(ac_q)] : 8'h00;
    assign LCD_DATA_OE = s2_q[10] & s2_q[8];
    assign LCD_DATA_O  = !LCD_DATA_OE ? 8'h00 : s2_q[9] ? rd_byte : {busy, ac_q};
    assign mon_data    = ddr_valid(mon_addr) ? mem_q[ddr_idx(mon_addr)] : 8'h00;

    // two-flop synchronizer plus one history stage for EN falling-edge detection
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            s1_q   <= '0;
            s2_q   <= '0;
            last_q <= '0;
        end else begin
            s1_q   <= {LCD_EN, LCD_RS, LCD_RW, LCD_DATA_I};
            s2_q   <= s1_q;
            last_q <= s2_q;
        end
    end

    // sequencer, instruction decode and DDRAM write port selection
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        ac_d     = ac_q;
        id_d     = id_q;
        s_d      = s_q;
        dcb_d    = dcb_q;
        ofs_d    = ofs_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        we       = 1'b0;
        wa       = fill_q;
        wd       = 8'h20;
        if (state_q == FILL) begin
            we = 1'b1;
            if (fill_q == 7'd79) begin
                state_d = BUSY;
                cnt_d   = CW'(CLEAR_CYCLES - 1);
            end else begin
                fill_d = fill_q + 7'd1;
            end
        end else if (state_q == BUSY) begin
            state_d = (cnt_q == '0) ? IDLE : BUSY;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
        end
        if (wr && state_q != IDLE) begin
            err_d = 1'b1;
        end else if (wr) begin
            strobe_d = 1'b1;
            state_d  = BUSY;
            cnt_d    = CW'(BUSY_CYCLES - 1);
            if (rs_l) begin
                we    = ddr_valid(ac_q);
                wa    = ddr_idx(ac_q);
                wd    = dat_l;
                ac_d  = ac_step(ac_q, id_q);
                ofs_d = s_q ? ofs_step(ofs_q, id_q) : ofs_q;
            end else if (dat_l[7]) begin
                ac_d = dat_l[6:0];
            end else if (dat_l[6] || dat_l[5]) begin
                // CGRAM address and function set are accepted with no visible effect
                ac_d = ac_q;
            end else if (dat_l[4]) begin
                ofs_d = dat_l[3] ? ofs_step(ofs_q, dat_l[2]) : ofs_q;
                ac_d  = dat_l[3] ? ac_q : ac_step(ac_q, dat_l[2]);
            end else if (dat_l[3]) begin
                dcb_d = dat_l[2:0];
            end else if (dat_l[2]) begin
                id_d = dat_l[1];
                s_d  = dat_l[0];
            end else if (dat_l[1]) begin
                ac_d  = 7'h00;
                ofs_d = 6'd0;
                cnt_d = CW'(CLEAR_CYCLES - 1);
            end else if (dat_l[0]) begin
                ac_d    = 7'h00;
                id_d    = 1'b1;
                ofs_d   = 6'd0;
                state_d = FILL;
                fill_d  = 7'd0;
            end
        end else if (rd && rs_l) begin
            ac_d = ac_step(ac_q, id_q);
        end
    end

    // control state; reset restarts the power-on fill sequence
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= FILL;
            fill_q   <= 7'd0;
            cnt_q    <= '0;
            ac_q     <= 7'h00;
            id_q     <= 1'b1;
            s_q      <= 1'b0;
            dcb_q    <= 3'b000;
            ofs_q    <= 6'd0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            ac_q     <= ac_d;
            id_q     <= id_d;
            s_q      <= s_d;
            dcb_q    <= dcb_d;
            ofs_q    <= ofs_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end

    // DDRAM has no reset; its contents come from the fill sequence and data writes
    always_ff @(posedge PCLK) begin
        if (we)
            mem_q[wa] <= wd;
    end
endmodule

// File: tb/tb_apb_charlcd_responder.sv
// tb_apb_charlcd_responder: scoreboard bench for the character LCD responder
module tb_apb_charlcd_responder;
    localparam int BC = 40;
    localparam int CC = 100;

    logic       PCLK = 0, PRESETn = 1, LCD_RS = 0, LCD_RW = 0, LCD_EN = 0;
    logic [7:0] LCD_DATA_I = 0, LCD_DATA_O, mon_data;
    logic       LCD_DATA_OE, busy, disp_on, cur_on, blink_on, cmd_strobe, err_busy;
    logic [6:0] mon_addr = 0, ac;
    logic [5:0] shift_ofs;

    apb_charlcd_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
        .LCD_DATA_I(LCD_DATA_I), .LCD_DATA_O(LCD_DATA_O), .LCD_DATA_OE(LCD_DATA_OE),
        .mon_addr(mon_addr), .mon_data(mon_data), .ac(ac), .busy(busy),
        .disp_on(disp_on), .cur_on(cur_on), .blink_on(blink_on), .shift_ofs(shift_ofs),
        .cmd_strobe(cmd_strobe), .err_busy(err_busy));

    always #5 PCLK = ~PCLK;

    typedef struct {bit err; int ac; int dcb; int ofs;} wexp_t;

    int    checks = 0, fails = 0;
    int    m_mem[128];
    int    m_ac, m_id, m_s, m_d, m_c, m_b, m_ofs, streak;
    bit    m_bsy;
    wexp_t wq[$];
    int    rq[$];
    int    bq[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic bit vld(input int a);
        return (a < 40) || (a >= 64 && a < 104);
    endfunction

    function automatic int stp(input int a, input bit inc);
        if (inc) return (a == 39) ? 64 : (a == 103) ? 0 : (a + 1) % 128;
        return (a == 0) ? 103 : (a == 64) ? 39 : (a + 127) % 128;
    endfunction

    function automatic int ostep(input int o, input bit inc);
        return inc ? (o + 1) % 40 : (o + 39) % 40;
    endfunction

    task automatic model_fill();
        for (int i = 0; i < 128; i++) m_mem[i] = vld(i) ? 32'h20 : 0;
    endtask

    task automatic push_w(input bit err);
        wexp_t w;
        w.err = err; w.ac = m_ac; w.dcb = m_d * 4 + m_c * 2 + m_b; w.ofs = m_ofs;
        wq.push_back(w);
    endtask

    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d);
        @(negedge PCLK);
        LCD_RS = rs; LCD_RW = rw; LCD_DATA_I = d; LCD_EN = 1;
        repeat (4) @(negedge PCLK);
        LCD_EN = 0;
        repeat (4) @(negedge PCLK);
    endtask

    task automatic wr(input bit rs, input int d);
        if (m_bsy) begin
            push_w(1);
        end else begin
            int len;
            len = BC;
            if (rs) begin
                if (vld(m_ac)) m_mem[m_ac] = d;
                m_ac = stp(m_ac, m_id != 0);
                if (m_s != 0) m_ofs = ostep(m_ofs, m_id != 0);
            end else if (d >= 128) m_ac = d - 128;
            else if (d >= 32) begin end
            else if (d >= 16) begin
                if ((d & 8) != 0) m_ofs = ostep(m_ofs, (d & 4) != 0);
                else m_ac = stp(m_ac, (d & 4) != 0);
            end else if (d >= 8) begin
                m_d = (d >> 2) & 1; m_c = (d >> 1) & 1; m_b = d & 1;
            end else if (d >= 4) begin
                m_id = (d >> 1) & 1; m_s = d & 1;
            end else if (d >= 2) begin
                m_ac = 0; m_ofs = 0; len = CC;
            end else if (d == 1) begin
                m_ac = 0; m_id = 1; m_ofs = 0; model_fill(); len = 80 + CC;
            end
            push_w(0);
            bq.push_back(len);
            m_bsy = 1;
        end
        xfer(rs, 0, 8'(d));
        streak++;
    endtask

    task automatic rd(input bit rs);
        if (rs) begin
            rq.push_back(vld(m_ac) ? m_mem[m_ac] : 0);
            m_ac = stp(m_ac, m_id != 0);
        end else begin
            rq.push_back((int'(m_bsy) << 7) | m_ac);
        end
        xfer(rs, 1, 8'h00);
        chk("oe_after_en_low", LCD_DATA_OE, 0);
        chk("dout_after_en_low", LCD_DATA_O, 0);
        streak++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge PCLK);
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge PCLK);
            n++;
        end
        chk("wait_idle", busy, 0);
        m_bsy = 0;
        streak = 0;
    endtask

    task automatic scan();
        for (int a = 0; a < 128; a++) begin
            mon_addr = 7'(a);
            #1;
            chk($sformatf("ddram[%0h]", a), mon_data, vld(a) ? m_mem[a] : 0);
        end
    endtask

    task automatic do_reset();
        PRESETn = 0;
        #1;
        chk("rst_ac", ac, 0);
        chk("rst_busy", busy, 1);
        chk("rst_oe", LCD_DATA_OE, 0);
        chk("rst_dout", LCD_DATA_O, 0);
        chk("rst_strobe", cmd_strobe, 0);
        chk("rst_err", err_busy, 0);
        chk("rst_dcb", {disp_on, cur_on, blink_on}, 0);
        chk("rst_ofs", shift_ofs, 0);
        bq.delete();
        bq.push_back(80 + CC);
        model_fill();
        m_ac = 0; m_id = 1; m_s = 0; m_d = 0; m_c = 0; m_b = 0; m_ofs = 0;
        m_bsy = 1; streak = 0;
        repeat (3) @(negedge PCLK);
        @(posedge PCLK);
        #3 PRESETn = 1;
    endtask

    // write monitor: every strobe or busy-drop pulse retires one expected write
    always @(negedge PCLK) begin
        wexp_t w;
        if (PRESETn && (cmd_strobe || err_busy)) begin
            if (wq.size() == 0) begin
                chk("unexpected_write_pulse", {cmd_strobe, err_busy}, 0);
            end else begin
                w = wq.pop_front();
                chk("w_kind", {cmd_strobe, err_busy}, w.err ? 2'b01 : 2'b10);
                chk("w_ac", ac, w.ac);
                chk("w_dcb", {disp_on, cur_on, blink_on}, w.dcb);
                chk("w_ofs", shift_ofs, w.ofs);
            end
        end
    end

    // read monitor: the first cycle the responder drives the bus retires one expected read
    logic oe_p = 0;
    always @(negedge PCLK) begin
        if (LCD_DATA_OE && !oe_p) begin
            if (rq.size() == 0) chk("unexpected_read", LCD_DATA_OE, 0);
            else chk("read_data", LCD_DATA_O, rq.pop_front());
        end
        oe_p = LCD_DATA_OE;
    end

    // busy monitor: length of each busy period after reset release
    int run = 0;
    always @(negedge PCLK) begin
        if (!PRESETn) run = 0;
        else if (busy === 1'b1) run++;
        else if (run > 0) begin
            if (bq.size() == 0) chk("unexpected_busy_len", run, 0);
            else chk("busy_len", run, bq.pop_front());
            run = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset();
        wait_idle();
        chk("idle_ac", ac, 0);
        chk("idle_disp", disp_on, 0);
        scan();
        wait_idle(); wr(0, 8'h06);
        wait_idle(); wr(0, 8'h0F);
        wait_idle(); wr(1, 8'h41);
        wait_idle(); wr(1, 8'h42);
        wait_idle();
        chk("ab_ac", ac, 2);
        mon_addr = 7'h00; #1; chk("ab_mem0", mon_data, 8'h41);
        mon_addr = 7'h01; #1; chk("ab_mem1", mon_data, 8'h42);
        wait_idle(); wr(0, 8'hA7);
        wait_idle(); wr(1, 8'h55);
        wait_idle();
        chk("wrap_ac", ac, 7'h40);
        mon_addr = 7'h27; #1; chk("wrap_mem27", mon_data, 8'h55);
        wait_idle(); wr(0, 8'h80);
        wait_idle(); wr(0, 8'h04);
        wait_idle(); wr(1, 8'h11);
        wait_idle();
        chk("dec_wrap_ac", ac, 7'h67);
        wr(0, 8'h85);
        wr(1, 8'h99);
        rd(0);
        wait_idle(); wr(0, 8'h06);
        wait_idle(); wr(0, 8'h80);
        wait_idle(); rd(1);
        chk("rd_step_ac", ac, 1);
        scan();
        for (int i = 0; i < 150; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (!(m_bsy && streak < 3 && $urandom_range(0, 1) == 1)) wait_idle();
            if (op < 4) wr(1, $urandom_range(0, 255));
            else if (op < 7) wr(0, ($urandom_range(0, 19) == 0) ? 1 : $urandom_range(2, 255));
            else rd(op > 7);
        end
        wait_idle();
        scan();
        wait_idle(); wr(0, 8'h80);
        wait_idle(); wr(1, 8'h5A);
        wait_idle(); wr(0, 8'h1C);
        wait_idle(); wr(0, 8'h01);
        wait_idle();
        chk("clr_ac", ac, 0);
        chk("clr_ofs", shift_ofs, 0);
        scan();
        wait_idle(); wr(1, 8'h77);
        wait_idle(); wr(0, 8'h02);
        repeat (30) @(negedge PCLK);
        do_reset();
        wait_idle();
        scan();
        wait_idle(); wr(1, 8'h66);
        wait_idle(); wr(0, 8'h01);
        repeat (20) @(negedge PCLK);
        do_reset();
        wait_idle();
        scan();
        repeat (5) @(negedge PCLK);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        chk("bq_drained", bq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/apb_charlcd_responder.md
APB_CHARLCD_RESPONDER -- requirements
Module: apb_charlcd_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 40, PCLK cycles BF stays high after a normal command/data write.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 1600, PCLK cycles BF stays high after clear/home, and after reset; SHALL be at least 80.
REQ-003 SHALL have ports, with clock and reset first:
  PCLK  in  1  sole clock, all state on rising edge
  PRESETn  in  1  reset, asynchronous assert, active-low
  LCD_RS  in  1  register select, 0=instruction, 1=data
  LCD_RW  in  1  0=write, 1=read
  LCD_EN  in  1  enable strobe, asynchronous to PCLK
  LCD_DATA_I  in  8  bus from controller
  LCD_DATA_O  out  8  bus to controller during reads
  LCD_DATA_OE  out  1  high while responder drives bus
  mon_addr  in  7  bench DDRAM peek address (HD44780 encoding)
  mon_data  out  8  DDRAM[mon_addr], combinational; 0x00 for invalid address
  ac  out  7  address counter
  busy  out  1  busy flag BF
  disp_on, cur_on, blink_on  out  1 each  display-control bits D, C, B
  shift_ofs  out  6  display shift offset, 0..39
  cmd_strobe  out  1  one-cycle pulse per accepted write
  err_busy  out  1  one-cycle pulse per write dropped while busy

Function
REQ-004 SHALL double-flop-synchronize LCD_EN, LCD_RS, LCD_RW, LCD_DATA_I; a transfer occurs on the synchronized EN falling edge, using RS/RW/DATA sampled the cycle before that edge.
REQ-005 SHALL hold an 80-byte DDRAM: valid addresses 0x00-0x27 (line 0) and 0x40-0x67 (line 1); writes to other addresses SHALL be dropped.
REQ-006 SHALL implement FSM IDLE, FILL, BUSY; IDLE accepts transfers, FILL writes 0x20 to one DDRAM entry per cycle for 80 cycles then enters BUSY, BUSY counts down to IDLE.
REQ-007 busy SHALL be 1 in FILL and BUSY, 0 in IDLE; BF countdown starts in the cycle after the EN falling edge.
REQ-008 A write (RW=0) arriving with busy=1 SHALL be ignored and pulse err_busy; reads are always serviced.
REQ-009 Instruction writes (RS=0) SHALL decode by highest set bit of data: 0x01 clear -> ac=0, I/D=1, shift_ofs=0, FILL; 0x02/0x03 home -> ac=0, shift_ofs=0, BUSY with CLEAR_CYCLES; 0x04-0x07 entry mode -> I/D=bit1, S=bit0; 0x08-0x0F -> D,C,B = bits 2,1,0; 0x10-0x1F -> bit3=1 display shift (bit2=1 right: shift_ofs+1 mod 40, else -1 mod 40), bit3=0 cursor move (ac +/-1 with wrap per REQ-011); 0x20-0x3F function set -> latched, no other effect; 0x40-0x7F CGRAM address -> accepted, no effect; 0x80-0xFF -> ac=data[6:0].
REQ-010 Data write (RS=1, RW=0) SHALL store byte at DDRAM[ac], then step ac per I/D; if S=1, shift_ofs SHALL also step (+1 when I/D=1, -1 otherwise, mod 40).
REQ-011 ac stepping SHALL wrap: increment 0x27->0x40, 0x67->0x00; decrement 0x00->0x67, 0x40->0x27; stepping from an invalid address SHALL simply add/subtract 1 mod 128.
REQ-012 Every accepted non-clear write SHALL enter BUSY with BUSY_CYCLES, except home (CLEAR_CYCLES); cmd_strobe SHALL pulse in the cycle the write takes effect.
REQ-013 Status read (RS=0, RW=1): LCD_DATA_OE=1 and LCD_DATA_O={busy, ac} while synchronized EN is high; no state change.
REQ-014 Data read (RS=1, RW=1): LCD_DATA_O=DDRAM[ac] (0x00 if invalid) while synchronized EN is high; on EN falling edge ac SHALL step per REQ-011; busy unchanged.
REQ-015 LCD_DATA_OE SHALL be 0 whenever RW (synchronized) is 0 or EN (synchronized) is 0.

Reset
REQ-016 PRESETn low SHALL immediately force: ac=0, I/D=1, S=0, D=C=B=0, shift_ofs=0, LCD_DATA_OE=0, LCD_DATA_O=0x00, cmd_strobe=0, err_busy=0, synchronizers to 0, FSM to FILL, busy=1.
REQ-017 After PRESETn release, FSM SHALL run FILL (80 cycles) then BUSY for CLEAR_CYCLES; DDRAM is not async-reset, its contents come only from this fill.
REQ-018 Reset asserted mid-FILL or mid-BUSY SHALL restart the full sequence of REQ-017.

Verification
REQ-019 Reset, wait until busy=0 -> all 80 valid mon_data = 0x20, ac=0x00, disp_on=0.
REQ-020 Write 0x06, 0x0F, then data 'A','B' (each after busy=0) -> mon_data[0x00]=0x41, [0x01]=0x42, ac=0x02, disp_on=cur_on=blink_on=1.
REQ-021 Write 0xA7 then data 0x55 -> DDRAM[0x27]=0x55, ac=0x40; write 0x80, entry 0x04, data 0x11 -> ac=0x67.
REQ-022 Write data while busy=1 -> err_busy pulses once, DDRAM and ac unchanged, busy countdown unaffected.
REQ-023 Status read with busy=1, ac=0x05 -> LCD_DATA_O=0x85, LCD_DATA_OE=1 only while EN high; data read at ac=0x00 returning 0x41 -> ac becomes 0x01.
REQ-024 Write 0x01 after filling text -> busy for 80+CLEAR_CYCLES, all valid entries 0x20, ac=0, shift_ofs=0.
